// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive GCD datapath: sequences operand loads,
// subtract steps and the result strobe, with a bounded iteration count.
module gcd_ctrl #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic x_gt_y,
    input  logic x_lt_y,
    input  logic x_eq_y,
    output logic x_sel,
    output logic y_sel,
    output logic x_sub,
    output logic y_sub,
    output logic x_ld,
    output logic y_ld,
    output logic data_en,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [3:0] {
        IDLE,
        LD_SET,
        LD_STB,
        CMP,
        SX_SET,
        SX_STB,
        SY_SET,
        SY_STB,
        OUT_STB,
        DONE,
        ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] cnt;
    logic [ITER_W-1:0] cnt_nxt;
    logic              cnt_sat;
    logic              accept;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_sat   = (cnt == ITER_W'(MAX_ITER));
        accept    = (state == IDLE) && start;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LD_SET;
                    cnt_nxt   = '0;
                end
            end
            LD_SET:  state_nxt = LD_STB;
            LD_STB:  state_nxt = CMP;
            CMP: begin
                // Exactly one flag must be set; anything else is a datapath fault.
                case ({x_gt_y, x_lt_y, x_eq_y})
                    3'b001: state_nxt = OUT_STB;
                    3'b100: begin
                        if (cnt_sat) begin
                            state_nxt = ERR;
                        end else begin
                            cnt_nxt   = cnt + ITER_W'(1);
                            state_nxt = SX_SET;
                        end
                    end
                    3'b010: begin
                        if (cnt_sat) begin
                            state_nxt = ERR;
                        end else begin
                            cnt_nxt   = cnt + ITER_W'(1);
                            state_nxt = SY_SET;
                        end
                    end
                    default: state_nxt = ERR;
                endcase
            end
            SX_SET:  state_nxt = SX_STB;
            SX_STB:  state_nxt = CMP;
            SY_SET:  state_nxt = SY_STB;
            SY_STB:  state_nxt = CMP;
            OUT_STB: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            x_sel   <= 1'b0;
            y_sel   <= 1'b0;
            x_sub   <= 1'b0;
            y_sub   <= 1'b0;
            x_ld    <= 1'b0;
            y_ld    <= 1'b0;
            data_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            x_sel   <= (state_nxt == LD_SET) || (state_nxt == LD_STB);
            y_sel   <= (state_nxt == LD_SET) || (state_nxt == LD_STB);
            y_sub   <= (state_nxt == SX_SET) || (state_nxt == SX_STB);
            x_sub   <= (state_nxt == SY_SET) || (state_nxt == SY_STB);
            x_ld    <= (state_nxt == LD_STB) || (state_nxt == SX_STB);
            y_ld    <= (state_nxt == LD_STB) || (state_nxt == SY_STB);
            data_en <= (state_nxt == OUT_STB);
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE) || (state_nxt == ERR);
            err     <= (state_nxt == ERR) || (err && !accept);
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a behavioural datapath drives the flags, and a plain
// arithmetic GCD model predicts result, subtraction count and done timing.
module tb_gcd_ctrl;

    localparam int MAX_IT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       x_gt_y, x_lt_y, x_eq_y;
    logic       x_sel, y_sel, x_sub, y_sub, x_ld, y_ld, data_en, busy, done, err;
    logic [7:0] x_i = 8'd0;
    logic [7:0] y_i = 8'd0;
    logic [7:0] reg_x = 8'd0;
    logic [7:0] reg_y = 8'd0;
    logic [7:0] data_o = 8'd0;
    bit         force_illegal = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    gcd_ctrl #(.ITER_W(8), .MAX_ITER(MAX_IT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_gt_y(x_gt_y), .x_lt_y(x_lt_y), .x_eq_y(x_eq_y),
        .x_sel(x_sel), .y_sel(y_sel), .x_sub(x_sub), .y_sub(y_sub),
        .x_ld(x_ld), .y_ld(y_ld), .data_en(data_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath registers clock on the rising edge of their load strobes.
    always @(posedge x_ld) begin
        if (x_sel) reg_x <= x_i;
        else if (y_sub) reg_x <= reg_x - reg_y;
    end
    always @(posedge y_ld) begin
        if (y_sel) reg_y <= y_i;
        else if (x_sub) reg_y <= reg_y - reg_x;
    end
    always @(posedge data_en) data_o <= reg_x;

    assign x_gt_y = force_illegal ? 1'b1 : (reg_x > reg_y);
    assign x_lt_y = force_illegal ? 1'b1 : (reg_x < reg_y);
    assign x_eq_y = force_illegal ? 1'b0 : (reg_x == reg_y);

    task automatic model(input int a0, input int b0, output int subs, output bit m_err,
                         output int g, output int done_c);
        int a = a0;
        int b = b0;
        subs = 0;
        m_err = 1'b0;
        g = 0;
        done_c = 0;
        forever begin
            if (a == b) begin
                g = a;
                done_c = 5 + 3 * subs;
                break;
            end
            if (subs == MAX_IT) begin
                m_err = 1'b1;
                done_c = 4 + 3 * subs;
                break;
            end
            if (a > b) a = a - b;
            else b = b - a;
            subs++;
        end
    endtask

    // One run from start acceptance (edge 0); cycle c is observed #1 after edge c-1.
    task automatic run(input logic [7:0] xa, input logic [7:0] ya, input int hold_start,
                       input bit illegal, output int done_c, output int done_n,
                       output logic err_d, output logic [7:0] dout, output int xs,
                       output int ys, output int xld_c, output int den_c, output int viol,
                       output logic busy_after);
        logic p_xld, p_yld, p_xsel, p_ysel, p_xsub, p_ysub;
        done_c = -1; done_n = 0; err_d = 1'bx; xs = 0; ys = 0;
        xld_c = -1; den_c = -1; viol = 0; busy_after = 1'bx;
        p_xld = 0; p_yld = 0; p_xsel = 0; p_ysel = 0; p_xsub = 0; p_ysub = 0;
        @(negedge clk);
        x_i = xa; y_i = ya; start = 1'b1; force_illegal = illegal;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            #1;
            if (c > hold_start) start = 1'b0;
            if (done) begin
                done_n++;
                if (done_c < 0) begin done_c = c; err_d = err; end
            end
            if (x_ld && y_sub) xs++;
            if (y_ld && x_sub) ys++;
            if (x_ld && xld_c < 0) xld_c = c;
            if (data_en && den_c < 0) den_c = c;
            if ((x_ld && p_xld) || (y_ld && p_yld)) viol++;
            if (x_ld && !((x_sel && p_xsel) || (y_sub && p_ysub))) viol++;
            if (y_ld && !((y_sel && p_ysel) || (x_sub && p_xsub))) viol++;
            if (p_xld && (x_sel || y_sub)) viol++;
            if (p_yld && (y_sel || x_sub)) viol++;
            if (done_c > 0 && c == done_c + 1) begin busy_after = busy; break; end
            p_xld = x_ld; p_yld = y_ld; p_xsel = x_sel; p_ysel = y_sel;
            p_xsub = x_sub; p_ysub = y_sub;
            @(posedge clk);
        end
        start = 1'b0;
        force_illegal = 1'b0;
        dout = data_o;
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b0; start = 1'b1; x_i = 8'd3; y_i = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({x_sel, y_sel, x_sub, y_sub, x_ld, y_ld, data_en, busy, done, err} !== 10'b0) begin
                n_errors++;
                $display("[TB] FAIL reset_outputs cyc%0d got %b want 0", i,
                         {x_sel, y_sel, x_sub, y_sub, x_ld, y_ld, data_en, busy, done, err});
            end
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_checks++;
        if ({busy, x_sel, y_sel} !== 3'b111) begin
            n_errors++;
            $display("[TB] FAIL first_start got %b want 111", {busy, x_sel, y_sel});
        end
        w = 0;
        while (!done && w < 20) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (!(done === 1'b1 && err === 1'b0 && data_o === 8'd3)) begin
            n_errors++;
            $display("[TB] FAIL first_run done=%b err=%b data=%0d want 1 0 3", done, err, data_o);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_equal();
        int dc, dn, xs, ys, xc, dec, viol; logic e, ba; logic [7:0] d;
        run(8'd7, 8'd7, 0, 1'b0, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
        n_checks++;
        if (xc !== 2 || dec !== 4 || dc !== 5) begin
            n_errors++;
            $display("[TB] FAIL equal_timing ld=%0d den=%0d done=%0d want 2 4 5", xc, dec, dc);
        end
        n_checks++;
        if (e !== 1'b0 || d !== 8'd7 || viol !== 0 || ba !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL equal_result err=%b data=%0d viol=%0d busy_after=%b want 0 7 0 0",
                     e, d, viol, ba);
        end
    endtask

    task automatic test_subtract();
        int dc, dn, xs, ys, xc, dec, viol; logic e, ba; logic [7:0] d;
        run(8'd12, 8'd18, 0, 1'b0, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
        n_checks++;
        if (dc !== 11 || d !== 8'd6 || e !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL sub_12_18 done=%0d data=%0d err=%b want 11 6 0", dc, d, e);
        end
        n_checks++;
        if (xs !== 1 || ys !== 1 || viol !== 0) begin
            n_errors++;
            $display("[TB] FAIL sub_strobes xs=%0d ys=%0d viol=%0d want 1 1 0", xs, ys, viol);
        end
    endtask

    task automatic test_saturate();
        int dc, dn, xs, ys, xc, dec, viol; logic e, ba; logic [7:0] d;
        run(8'd0, 8'd5, 0, 1'b0, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
        n_checks++;
        if (ys !== MAX_IT || xs !== 0 || dc !== 4 + 3 * MAX_IT || e !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL saturate ys=%0d xs=%0d done=%0d err=%b want %0d 0 %0d 1",
                     ys, xs, dc, e, MAX_IT, 4 + 3 * MAX_IT);
        end
        n_checks++;
        if (ba !== 1'b0 || dn !== 1) begin
            n_errors++;
            $display("[TB] FAIL saturate_busy busy_after=%b done_n=%0d want 0 1", ba, dn);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL err_hold err=%b busy=%b want 1 0", err, busy);
        end
        @(negedge clk); x_i = 8'd4; y_i = 8'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL err_clear err=%b busy=%b want 0 1", err, busy);
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic test_illegal();
        int dc, dn, xs, ys, xc, dec, viol; logic e, ba; logic [7:0] d;
        run(8'd9, 8'd3, 3, 1'b1, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
        n_checks++;
        if (dc !== 4 || e !== 1'b1 || dn !== 1 || dec !== -1) begin
            n_errors++;
            $display("[TB] FAIL illegal_flags done=%0d err=%b done_n=%0d den=%0d want 4 1 1 -1",
                     dc, e, dn, dec);
        end
        n_checks++;
        if (ba !== 1'b0 || xs !== 0 || ys !== 0) begin
            n_errors++;
            $display("[TB] FAIL illegal_after busy=%b xs=%0d ys=%0d want 0 0 0", ba, xs, ys);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, dn, xs, ys, xc, dec, viol, seen; logic e, ba; logic [7:0] d;
        @(negedge clk); x_i = 8'd20; y_i = 8'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (x_ld !== 1'b1 || y_sub !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL sx_stb_reach x_ld=%b y_sub=%b want 1 1", x_ld, y_sub);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({x_ld, y_sub, busy, done} !== 4'b0) begin
            n_errors++;
            $display("[TB] FAIL mid_reset got %b want 0000", {x_ld, y_sub, busy, done});
        end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (done || busy) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("[TB] FAIL post_reset_quiet activity=%0d want 0", seen);
        end
        run(8'd20, 8'd5, 0, 1'b0, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
        n_checks++;
        if (dc !== 14 || d !== 8'd5 || e !== 1'b0 || xs !== 3) begin
            n_errors++;
            $display("[TB] FAIL rerun done=%0d data=%0d err=%b xs=%0d want 14 5 0 3", dc, d, e, xs);
        end
    endtask

    task automatic test_random();
        int dc, dn, xs, ys, xc, dec, viol, m_subs, m_g, m_dc; logic e, ba; logic [7:0] d;
        bit m_err; logic [7:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 40));
            b = 8'($urandom_range(0, 40));
            model(int'(a), int'(b), m_subs, m_err, m_g, m_dc);
            run(a, b, 0, 1'b0, dc, dn, e, d, xs, ys, xc, dec, viol, ba);
            n_checks++;
            if (dc !== m_dc || e !== m_err || (xs + ys) !== m_subs || viol !== 0 || ba !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL rand_%0d_%0d done=%0d err=%b subs=%0d viol=%0d busy=%b want %0d %b %0d 0 0",
                         a, b, dc, e, xs + ys, viol, ba, m_dc, m_err, m_subs);
            end
            if (!m_err) begin
                n_checks++;
                if (d !== 8'(m_g)) begin
                    n_errors++;
                    $display("[TB] FAIL rand_gcd_%0d_%0d got %0d want %0d", a, b, d, m_g);
                end
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_subtract();
        test_saturate();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
